// File: rtl/sgm_sys_pkg.sv
// Shared constants for the SGMatch system-level sequencing logic.
// Holds the init FSM state encoding and the default stage timing values.
package sgm_sys_pkg;

  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_DONE = 1'b1;

  localparam int CNT_W_DEF        = 24;
  localparam int DELAY_50MS_50MHZ = 2500000;

endpackage

// File: rtl/system_init_seq_stage_timer.sv
// Per-stage delay counter: counts enabled cycles, pulses expire combinationally on the
// cycle it sits at the terminal value and wraps to zero on that edge; clear has priority.
module stage_timer
  import sgm_sys_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] term,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  assign expire = enable && !clear && (cnt == term);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= expire ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/system_init_seq.sv
// Power-on sequencer releasing a thermometer stage_done vector, one stage per programmed delay.
// All outputs registered; restart clears on the edge it is sampled, hold freezes counting in RUN.
module system_init_seq
  import sgm_sys_pkg::*;
#(
  parameter int                          NUM_STAGES   = 4,
  parameter int                          CNT_W        = CNT_W_DEF,
  parameter logic [NUM_STAGES*CNT_W-1:0] STAGE_DELAYS = {NUM_STAGES{CNT_W'(DELAY_50MS_50MHZ)}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  restart,
  input  logic                  hold,
  output logic [NUM_STAGES-1:0] stage_done,
  output logic                  all_done,
  output logic                  busy,
  output logic [3:0]            stage_idx
);

  logic                  state;
  logic [CNT_W-1:0]      delay_sel;
  logic [CNT_W-1:0]      term;
  logic [NUM_STAGES-1:0] idx_onehot;
  logic                  timer_en;
  logic                  expire;
  logic                  last_stage;

  always_comb begin
    delay_sel  = '0;
    idx_onehot = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (stage_idx == 4'(k)) begin
        delay_sel     = STAGE_DELAYS[k*CNT_W +: CNT_W];
        idx_onehot[k] = 1'b1;
      end
    end
  end

  // A zero delay is treated as one cycle so no stage completes combinationally.
  assign term       = (delay_sel == '0) ? '0 : delay_sel - CNT_W'(1);
  assign timer_en   = (state == ST_RUN) && !hold;
  assign last_stage = (stage_idx == 4'(NUM_STAGES - 1));

  stage_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (restart),
    .enable (timer_en),
    .term   (term),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      stage_idx  <= '0;
      stage_done <= '0;
      busy       <= 1'b1;
    end else if (restart) begin
      state      <= ST_RUN;
      stage_idx  <= '0;
      stage_done <= '0;
      busy       <= 1'b1;
    end else if ((state == ST_RUN) && expire) begin
      stage_done <= stage_done | idx_onehot;
      if (last_stage) begin
        state <= ST_DONE;
        busy  <= 1'b0;
      end else begin
        stage_idx <= stage_idx + 4'd1;
      end
    end
  end

  assign all_done = stage_done[NUM_STAGES-1];

endmodule

// File: tb/tb_system_init_seq.sv
// Scoreboard bench for system_init_seq: stimulus pushes expected output changes with their
// edge numbers, a negedge monitor pops and compares whenever a DUT's outputs change.
module tb_system_init_seq;

  typedef struct {
    int         id;
    int         edge_n;
    logic [9:0] snap;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  exp_t sb[$];
  logic [9:0] prev_snap [4];

  // dut_a: delays {5,3,1}; dut_b: delays {0,2,0}; dut_c: 4 x 1000; dut_d: all defaults
  logic rst_n_a, restart_a, hold_a, all_a, busy_a;
  logic [2:0] done_a;
  logic [3:0] idx_a;
  logic rst_n_b, restart_b, hold_b, all_b, busy_b;
  logic [2:0] done_b;
  logic [3:0] idx_b;
  logic rst_n_c, restart_c, hold_c, all_c, busy_c;
  logic [3:0] done_c;
  logic [3:0] idx_c;
  logic rst_n_d, restart_d, hold_d, all_d, busy_d;
  logic [3:0] done_d;
  logic [3:0] idx_d;

  int e_a, e_b, e_c;

  system_init_seq #(.NUM_STAGES(3), .CNT_W(8), .STAGE_DELAYS({8'd1, 8'd3, 8'd5})) dut_a (
    .clk(clk), .rst_n(rst_n_a), .restart(restart_a), .hold(hold_a),
    .stage_done(done_a), .all_done(all_a), .busy(busy_a), .stage_idx(idx_a));

  system_init_seq #(.NUM_STAGES(3), .CNT_W(8), .STAGE_DELAYS({8'd0, 8'd2, 8'd0})) dut_b (
    .clk(clk), .rst_n(rst_n_b), .restart(restart_b), .hold(hold_b),
    .stage_done(done_b), .all_done(all_b), .busy(busy_b), .stage_idx(idx_b));

  system_init_seq #(.STAGE_DELAYS({4{24'd1000}})) dut_c (
    .clk(clk), .rst_n(rst_n_c), .restart(restart_c), .hold(hold_c),
    .stage_done(done_c), .all_done(all_c), .busy(busy_c), .stage_idx(idx_c));

  system_init_seq dut_d (
    .clk(clk), .rst_n(rst_n_d), .restart(restart_d), .hold(hold_d),
    .stage_done(done_d), .all_done(all_d), .busy(busy_d), .stage_idx(idx_d));

  // Edge n is the n-th rising edge after the DUT's reset was released.
  always @(posedge clk or negedge rst_n_a) if (!rst_n_a) e_a <= 0; else e_a <= e_a + 1;
  always @(posedge clk or negedge rst_n_b) if (!rst_n_b) e_b <= 0; else e_b <= e_b + 1;
  always @(posedge clk or negedge rst_n_c) if (!rst_n_c) e_c <= 0; else e_c <= e_c + 1;

  function automatic logic [9:0] mk(input logic [3:0] d, input logic b, input logic a,
                                    input logic [3:0] ix);
    return {d, b, a, ix};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input int edge_n, input logic [3:0] d, input logic b,
                      input logic a, input logic [3:0] ix);
    exp_t x;
    x.id     = id;
    x.edge_n = edge_n;
    x.snap   = mk(d, b, a, ix);
    sb.push_back(x);
  endtask

  task automatic observe(input int id, input logic rn, input int e, input logic [9:0] snap);
    exp_t x;
    if (!rn) begin
      prev_snap[id] = snap;
    end else if (snap != prev_snap[id]) begin
      prev_snap[id] = snap;
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_change dut%0d edge %0d: outputs 0x%0h, required no change",
                 id, e, snap);
      end else begin
        x = sb.pop_front();
        chk($sformatf("event_dut_id@%0d", e), id, x.id);
        chk($sformatf("event_edge_dut%0d", id), e, x.edge_n);
        chk($sformatf("event_outputs_dut%0d_edge%0d", id, e), {22'd0, snap}, {22'd0, x.snap});
      end
    end
  endtask

  always @(negedge clk) begin
    observe(0, rst_n_a, e_a, mk({1'b0, done_a}, busy_a, all_a, idx_a));
    observe(1, rst_n_b, e_b, mk({1'b0, done_b}, busy_b, all_b, idx_b));
    observe(2, rst_n_c, e_c, mk(done_c, busy_c, all_c, idx_c));
    observe(3, rst_n_d, 0, mk(done_d, busy_d, all_d, idx_d));
  end

  // mode 0: free run; mode 1: hold on edges 6..9; mode 2: restart/hold schedule incl. DONE.
  task automatic run_a(input int n, input int mode);
    for (int e = 1; e <= n; e++) begin
      hold_a    = (mode == 1 && e >= 6 && e <= 9) || (mode == 2 && e >= 18 && e <= 20);
      restart_a = (mode == 2) && (e == 7 || e == 22 || (e >= 34 && e <= 36));
      @(posedge clk);
      @(negedge clk);
      if (mode == 2 && e == 20) begin
        chk("hold_in_done_stage_done", 32'(done_a), 32'h7);
        chk("hold_in_done_busy", 32'(busy_a), 32'h0);
      end
      if (mode == 2 && e == 35) begin
        chk("held_restart_stage_done", 32'(done_a), 32'h0);
        chk("held_restart_busy", 32'(busy_a), 32'h1);
        chk("held_restart_idx", 32'(idx_a), 32'h0);
      end
    end
    hold_a    = 1'b0;
    restart_a = 1'b0;
  endtask

  task automatic reset_a();
    rst_n_a = 1'b0;
    repeat (2) @(negedge clk);
    rst_n_a = 1'b1;
  endtask

  initial begin
    rst_n_a = 1'b0; restart_a = 1'b0; hold_a = 1'b0;
    rst_n_b = 1'b0; restart_b = 1'b0; hold_b = 1'b0;
    rst_n_c = 1'b0; restart_c = 1'b0; hold_c = 1'b0;
    rst_n_d = 1'b0; restart_d = 1'b0; hold_d = 1'b0;
    repeat (2) @(negedge clk);

    chk("reset_stage_done", 32'(done_a), 32'h0);
    chk("reset_all_done", 32'(all_a), 32'h0);
    chk("reset_busy", 32'(busy_a), 32'h1);
    chk("reset_stage_idx", 32'(idx_a), 32'h0);
    chk("reset_default_busy", 32'(busy_d), 32'h1);

    rst_n_a = 1'b1;
    rst_n_d = 1'b1;

    // Free run {5,3,1}
    push(0, 5, 4'b0001, 1'b1, 1'b0, 4'd1);
    push(0, 8, 4'b0011, 1'b1, 1'b0, 4'd2);
    push(0, 9, 4'b0111, 1'b0, 1'b1, 4'd2);
    run_a(12, 0);
    #1 chk("pending_free_run", sb.size(), 0);

    // Hold for edges 6..9 pushes stages 1 and 2 out by four cycles
    reset_a();
    push(0, 5, 4'b0001, 1'b1, 1'b0, 4'd1);
    push(0, 12, 4'b0011, 1'b1, 1'b0, 4'd2);
    push(0, 13, 4'b0111, 1'b0, 1'b1, 4'd2);
    run_a(16, 1);
    #1 chk("pending_hold", sb.size(), 0);

    // Restart at 7, hold in DONE 18..20, restart pulse at 22, restart held 34..36
    reset_a();
    push(0, 5, 4'b0001, 1'b1, 1'b0, 4'd1);
    push(0, 7, 4'b0000, 1'b1, 1'b0, 4'd0);
    push(0, 12, 4'b0001, 1'b1, 1'b0, 4'd1);
    push(0, 15, 4'b0011, 1'b1, 1'b0, 4'd2);
    push(0, 16, 4'b0111, 1'b0, 1'b1, 4'd2);
    push(0, 22, 4'b0000, 1'b1, 1'b0, 4'd0);
    push(0, 27, 4'b0001, 1'b1, 1'b0, 4'd1);
    push(0, 30, 4'b0011, 1'b1, 1'b0, 4'd2);
    push(0, 31, 4'b0111, 1'b0, 1'b1, 4'd2);
    push(0, 34, 4'b0000, 1'b1, 1'b0, 4'd0);
    push(0, 41, 4'b0001, 1'b1, 1'b0, 4'd1);
    push(0, 44, 4'b0011, 1'b1, 1'b0, 4'd2);
    push(0, 45, 4'b0111, 1'b0, 1'b1, 4'd2);
    run_a(50, 2);
    #1 chk("pending_restart", sb.size(), 0);
    rst_n_a = 1'b0;

    // Zero delays cost exactly one cycle each: {0,2,0}
    @(negedge clk);
    rst_n_b = 1'b1;
    push(1, 1, 4'b0001, 1'b1, 1'b0, 4'd1);
    push(1, 3, 4'b0011, 1'b1, 1'b0, 4'd2);
    push(1, 4, 4'b0111, 1'b0, 1'b1, 4'd2);
    repeat (8) @(negedge clk);
    #1 chk("pending_zero_delay", sb.size(), 0);
    rst_n_b = 1'b0;

    // Four 1000-cycle stages, asynchronous reset in the middle of stage 2
    @(negedge clk);
    rst_n_c = 1'b1;
    push(2, 1000, 4'b0001, 1'b1, 1'b0, 4'd1);
    push(2, 2000, 4'b0011, 1'b1, 1'b0, 4'd2);
    repeat (2500) @(negedge clk);
    #1 chk("pending_before_reset", sb.size(), 0);
    #2 rst_n_c = 1'b0;
    #1;
    chk("async_reset_stage_done", 32'(done_c), 32'h0);
    chk("async_reset_all_done", 32'(all_c), 32'h0);
    chk("async_reset_stage_idx", 32'(idx_c), 32'h0);
    chk("async_reset_busy", 32'(busy_c), 32'h1);
    repeat (2) @(negedge clk);
    rst_n_c = 1'b1;
    push(2, 1000, 4'b0001, 1'b1, 1'b0, 4'd1);
    repeat (1003) @(negedge clk);
    #1 chk("pending_after_reset", sb.size(), 0);

    // Defaults: 50 ms per stage, so nothing may have completed yet
    chk("default_stage_done", 32'(done_d), 32'h0);
    chk("default_all_done", 32'(all_d), 32'h0);
    chk("default_busy", 32'(busy_d), 32'h1);
    chk("default_stage_idx", 32'(idx_d), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/system_init_seq.md
# system_init_seq

Parametrised power-on sequencer for the SGMatch system. It replaces the single fixed 50 ms init delay with NUM_STAGES cascaded delays, each with its own length. It releases a thermometer-coded `stage_done` vector so that clocking, sensor configuration and the SGM pipeline come out of init in a fixed order. It adds a synchronous restart, for example after a sensor re-configuration, and a hold input that freezes the sequence while an external resource is not ready.

## Interface
- NUM_STAGES, 4, number of sequenced stages (1..16)
- CNT_W, 24, counter width; every delay must be < 2^CNT_W
- STAGE_DELAYS, {4{24'd2500000}}, packed NUM_STAGES*CNT_W vector; slice k = [k*CNT_W +: CNT_W] is the delay of stage k in clk cycles (50 ms at 50 MHz)
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- restart  input  1  synchronous re-run request, level-sampled
- hold  input  1  freezes the running stage counter while high
- stage_done  output  NUM_STAGES  thermometer; bit k high once stages 0..k have completed
- all_done  output  1  equals stage_done[NUM_STAGES-1]
- busy  output  1  high while the sequence is running
- stage_idx  output  4  index of the stage currently counting; holds NUM_STAGES-1 when done

## Operation
- State machine has two states, RUN and DONE.
- Reset (rst_n low, asynchronous) sets: state = RUN, cnt = 0, stage_idx = 0, stage_done = 0, all_done = 0, busy = 1.
- RUN, per rising edge, with priority restart > hold > count:
  - restart = 1: cnt = 0, stage_idx = 0, stage_done = 0, state stays RUN.
  - hold = 1: all registers unchanged.
  - cnt == Dk-1, where Dk is the effective delay of the current stage: cnt = 0 and stage_done[stage_idx] = 1.
    - If stage_idx == NUM_STAGES-1, go to DONE and keep stage_idx.
    - Otherwise stage_idx increments.
  - Otherwise cnt increments.
- DONE:
  - All outputs are stable: stage_done all ones, all_done = 1, busy = 0.
  - hold is ignored.
  - restart = 1 applies the same clearing as in RUN and returns to RUN.
- Effective delay Dk = max(STAGE_DELAYS[k], 1). A zero delay therefore costs exactly one cycle; stages are never skipped combinationally.
- Counter arithmetic is CNT_W bits, unsigned. cnt never exceeds Dk-1, so it cannot wrap.
- stage_done bits only set in index order and never clear except by restart or reset.
- busy = (state == RUN), registered. It stays high through a held restart.
- restart held high across several cycles keeps the block cleared. Counting starts on the first edge after restart is sampled low.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- With no hold and no restart, stage_done[k] rises on clock edge S_k = D0 + … + Dk after rst_n deasserts. For a single stage this matches the old behaviour of N edges for a delay of N.
- Each hold cycle delays every later stage_done edge by exactly one cycle.
- After restart is sampled high at edge R, with restart low from then on, stage_done[k] rises at edge R + S_k.
- all_done and the DONE transition occur on the same edge as stage_done[NUM_STAGES-1].
- busy falls on that same edge.
- Reset asserted mid-sequence clears all outputs immediately, without waiting for a clock edge.

## Structure
- Shared package `sgm_sys_pkg` holds:
  - the state encoding (RUN = 1'b0, DONE = 1'b1);
  - the default CNT_W;
  - the constant DELAY_50MS_50MHZ = 2500000.
- One sub-module, `stage_timer`: a CNT_W-bit counter with inputs clear, enable and terminal value, and a one-cycle `expire` output.
- The top module holds the FSM, stage_idx, stage_done, and the mux that selects Dk from STAGE_DELAYS.

## Test plan
- NUM_STAGES=3, delays {5,3,1}, no hold or restart -> stage_done = 001 at edge 5, 011 at edge 8, 111 at edge 9; busy falls at edge 9; stage_idx reads 0,1,2.
- Delays {0,2,0} -> stage_done bits rise at edges 1, 3, 4; no bit is skipped or set early.
- Delays {5,3,1}, hold high for edges 6–9 (4 cycles) -> stage_done[1] at edge 12, stage_done[2] at edge 13.
- Delays {5,3,1}, restart high for one cycle at edge 7 -> stage_done cleared at edge 7; bits then rise at edges 12, 15, 16.
- restart pulsed in DONE; restart held high for 3 cycles -> outputs stay cleared and busy stays high while restart is high; the sequence re-runs from its low edge. A hold applied in DONE has no effect.
- Default parameters; rst_n pulsed low mid-stage 2 -> all outputs 0 asynchronously; after release, stage_done[0] rises exactly 2,500,000 edges later.
